gate_identifier: RTL



---
 rtl/gate_identifier.sv | 108 ++++++++++
 1 files changed

// File: rtl/gate_identifier.sv
// gate_identifier: sweeps {a,b} through 00..11 into an external gate, samples y after SETTLE cycles, classifies the truth table.
// Define GATE_IDENTIFIER_RECHECK_EN to run each sweep twice and flag gates whose two passes disagree.
module gate_identifier #(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic       y_i,
  output logic       a_o,
  output logic       b_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [3:0] tt_o,
  output logic [2:0] gate_o,
  output logic       valid_o
);
`ifdef GATE_IDENTIFIER_RECHECK_EN
  localparam int IW = 3;
`else
  localparam int IW = 2;
`endif
  localparam int N = 1 << IW;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] i_q, i_d;
  logic [3:0] cnt_q, cnt_d;
  logic [N-1:0] t_q, t_d, full;
  logic [3:0] tt_q, tt_d;
  logic [2:0] gate_q, gate_d, code;
  logic valid_q, valid_d, done_q, done_d, sample;
  // The final sample is not stored yet when results load, so splice it in from y
  assign full = {y_i, t_q[N-2:0]};
  assign sample = (state_q == RUN) && (cnt_q == 4'(SETTLE - 1));
  assign a_o = i_q[1];
  assign b_o = i_q[0];
  assign busy_o = state_q == RUN;
  assign done_o = done_q;
  assign tt_o = tt_q;
  assign gate_o = gate_q;
  assign valid_o = valid_q;
  always_comb begin
    case (full[3:0])
      4'b1000: code = 3'd0;
      4'b1110: code = 3'd1;
      4'b0101: code = 3'd2;
      4'b0111: code = 3'd3;
      4'b0001: code = 3'd4;
      4'b0110: code = 3'd5;
      4'b1001: code = 3'd6;
      default: code = 3'd7;
    endcase
`ifdef GATE_IDENTIFIER_RECHECK_EN
    if (full[N-1:4] != full[3:0]) code = 3'd7;
`endif
  end
  always_comb begin
    state_d = state_q;
    i_d = i_q;
    cnt_d = cnt_q;
    t_d = t_q;
    tt_d = tt_q;
    gate_d = gate_q;
    valid_d = valid_q;
    done_d = 1'b0;
    if (state_q == IDLE) begin
      if (start_i) begin
        state_d = RUN;
        i_d = '0;
        cnt_d = '0;
      end
    end else if (sample) begin
      cnt_d = '0;
      i_d = i_q + IW'(1);
      t_d[i_q] = y_i;
      if (&i_q) begin
        state_d = IDLE;
        done_d = 1'b1;
        tt_d = full[3:0];
        gate_d = code;
        valid_d = code != 3'd7;
      end
    end else begin
      cnt_d = cnt_q + 4'd1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      i_q <= '0;
      cnt_q <= '0;
      t_q <= '0;
      tt_q <= '0;
      gate_q <= 3'd7;
      valid_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q <= i_d;
      cnt_q <= cnt_d;
      t_q <= t_d;
      tt_q <= tt_d;
      gate_q <= gate_d;
      valid_q <= valid_d;
      done_q <= done_d;
    end
  end
endmodule
